alu_32: RTL and testbench
=========================

Name: alu_32

Overview:
- 32-bit registered integer ALU: two operands, 4-bit opcode, one result and four status flags (Z, C, V, S).
- Covers arithmetic (add, sub, mul, div), bitwise logic (and, or, xor, not) and single-bit shifts.
- Sits in the execute stage of the datapath; result and flags are registered, with one cycle of latency.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported and verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  operands and opcode are valid this cycle
- A  input  32  operand A
- B  input  32  operand B
- ALU_Sel  input  4  opcode
- out_valid  output  1  ALU_Out and flags hold a new result
- ALU_Out  output  32  registered result
- Z  output  1  zero flag
- C  output  1  carry/borrow flag
- V  output  1  overflow flag
- S  output  1  sign flag

Behaviour:
- Clocking: one clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset: when rst_n=0 at a clk edge, ALU_Out=0, Z=0, C=0, V=0, S=0, out_valid=0.
  - Reset overrides in_valid in the same cycle; no result is produced.
- Latency: A, B and ALU_Sel are sampled at edge N when in_valid=1. Result and flags appear after edge N, with out_valid=1 for exactly that cycle.
- Idle: in_valid=0 gives out_valid=0 on the next cycle. ALU_Out and the flags hold their last values.
- Back-to-back: one operation is accepted per cycle; there is no stall and no backpressure.
- Opcodes (unsigned unless stated):
  - 0000 ADD: A+B. C=carry out of bit 31. V=signed overflow (operands same sign, result sign differs).
  - 0001 SUB: A-B. C=borrow (1 when A<B unsigned). V=signed overflow (operands differ in sign, result sign differs from A).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise. C=0, V=0.
  - 0101 NOT: ~A; B is ignored. C=0, V=0.
  - 0110 MUL: low 32 bits of the unsigned 64-bit product A*B. C=V=1 when the upper 32 bits are nonzero, else 0.
  - 0111 DIV: unsigned quotient A/B. C=0, V=0.
    - B=0: ALU_Out=32'hFFFF_FFFF, V=1, C=0.
  - 1000 SHL: A<<1, zero fill; B is ignored. C=A[31], V=0.
  - 1001 SHR: logical A>>1, zero fill; B is ignored. C=A[0], V=0.
  - 1010-1111: ALU_Out=0, C=0, V=0, unless the optional feature below is compiled in.
- Flags for all opcodes: Z=(ALU_Out==0); S=ALU_Out[31].
- Division is single-cycle combinational before the output register; no multicycle path is allowed.

Optional Feature:
- Macro: ALU32_ROTATE_EN.
- Defined: opcode 1010 ROL (A rotated left by 1, C=A[31]) and 1011 ROR (A rotated right by 1, C=A[0]). V=0; Z and S follow the normal rule. 1100-1111 stay reserved (result 0).
- Not defined: 1010 and 1011 behave as reserved: ALU_Out=0, C=0, V=0, Z=1, S=0.

Test Plan:
- Reset, then ADD A=32'h1 B=32'h2 -> out_valid=1 one cycle later, ALU_Out=32'h3, Z=0 C=0 V=0 S=0.
  - Next, SUB A=32'h4 B=32'h5 -> 32'hFFFF_FFFF, Z=0 C=1 V=0 S=1.
- AND 32'hF0F0_F0F0 & 32'h0F0F_0F0F -> 32'h0, Z=1.
  - OR 32'hAAAA_AAAA | 32'h5555_5555 -> 32'hFFFF_FFFF, S=1.
  - XOR 32'hFFFF_0000 ^ 32'h0000_FFFF -> 32'hFFFF_FFFF, S=1.
  - NOT A=32'h0 -> 32'hFFFF_FFFF, S=1.
- MUL 3*2 -> 32'h6, C=V=0.
  - MUL 32'h1_0000 * 32'h1_0000 -> 32'h0, Z=1 C=1 V=1.
  - DIV 6/3 -> 32'h2.
  - DIV 6/0 -> 32'hFFFF_FFFF, V=1.
- SHL A=32'h1 -> 32'h2, C=0.
  - SHR A=32'h8000_0000 -> 32'h4000_0000, C=0.
  - SHL A=32'h8000_0000 -> 32'h0, Z=1 C=1.
- ADD overflow 32'h7FFF_FFFF+32'h1 -> 32'h8000_0000, V=1 S=1 C=0.
  - ADD 32'hFFFF_FFFF+32'h1 -> 32'h0, C=1 Z=1.
- Reset mid-stream: assert rst_n=0 together with in_valid=1 -> next cycle all outputs 0, out_valid=0.
  - Then in_valid=0 for 3 cycles -> out_valid stays 0, outputs hold 0.

Source files
------------

// File: rtl/alu_32_if.sv
// Operand/opcode request and registered result/flag bundle for alu_32.
// master drives operands and observes results; slave is the ALU itself.
interface alu_32_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_Sel;
   logic             out_valid;
   logic [WIDTH-1:0] ALU_Out;
   logic             Z;
   logic             C;
   logic             V;
   logic             S;

   modport master (
      output in_valid, A, B, ALU_Sel,
      input  out_valid, ALU_Out, Z, C, V, S
   );

   modport slave (
      input  in_valid, A, B, ALU_Sel,
      output out_valid, ALU_Out, Z, C, V, S
   );
endinterface

// File: rtl/alu_32.sv
// 32-bit ALU with Z/C/V/S flags; ALU32_ROTATE_EN adds ROL (1010) and ROR (1011).
// Latency: one cycle, result and flags registered, out_valid pulses once per accepted op.
// Backpressure: none, one operation accepted every cycle; idle cycles hold the last result.
module alu_32 #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_32_if.slave   bus
);
   typedef enum logic [3:0] {
      OP_ADD = 4'h0,
      OP_SUB = 4'h1,
      OP_AND = 4'h2,
      OP_OR  = 4'h3,
      OP_XOR = 4'h4,
      OP_NOT = 4'h5,
      OP_MUL = 4'h6,
      OP_DIV = 4'h7,
      OP_SHL = 4'h8,
      OP_SHR = 4'h9,
      OP_ROL = 4'hA,
      OP_ROR = 4'hB
   } op_e;

   typedef struct packed {
      logic z;
      logic c;
      logic v;
      logic s;
   } flags_t;

   op_e                op;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   res;
   logic               carry;
   logic               ovf;
   flags_t             flags;

   assign op   = op_e'(bus.ALU_Sel);
   assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
   // Top bit of the widened difference is the unsigned borrow (A < B).
   assign diff = {1'b0, bus.A} - {1'b0, bus.B};
   assign prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
   assign quot = (bus.B == '0) ? '1 : (bus.A / bus.B);

   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff[WIDTH-1:0];
            carry = diff[WIDTH];
            ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND: res = bus.A & bus.B;
         OP_OR:  res = bus.A | bus.B;
         OP_XOR: res = bus.A ^ bus.B;
         OP_NOT: res = ~bus.A;
         OP_MUL: begin
            res   = prod[WIDTH-1:0];
            carry = |prod[2*WIDTH-1:WIDTH];
            ovf   = |prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            res = quot;
            ovf = (bus.B == '0);
         end
         OP_SHL: begin
            res   = {bus.A[WIDTH-2:0], 1'b0};
            carry = bus.A[WIDTH-1];
         end
         OP_SHR: begin
            res   = {1'b0, bus.A[WIDTH-1:1]};
            carry = bus.A[0];
         end
`ifdef ALU32_ROTATE_EN
         OP_ROL: begin
            res   = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            carry = bus.A[WIDTH-1];
         end
         OP_ROR: begin
            res   = {bus.A[0], bus.A[WIDTH-1:1]};
            carry = bus.A[0];
         end
`endif
         default: begin
            res   = '0;
            carry = 1'b0;
            ovf   = 1'b0;
         end
      endcase
   end

   always_comb begin
      flags   = '0;
      flags.z = (res == '0);
      flags.c = carry;
      flags.v = ovf;
      flags.s = res[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.ALU_Out   <= '0;
         bus.Z         <= 1'b0;
         bus.C         <= 1'b0;
         bus.V         <= 1'b0;
         bus.S         <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.ALU_Out <= res;
            bus.Z       <= flags.z;
            bus.C       <= flags.c;
            bus.V       <= flags.v;
            bus.S       <= flags.s;
         end
      end
   end
endmodule

// File: tb/tb_alu_32.sv
// Bench for alu_32: directed vectors push expected results into a queue,
// a monitor pops and compares every cycle out_valid is high.
module tb_alu_32;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alu_32_if #(.WIDTH(32)) bus ();

   alu_32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  zcvs;
      int          id;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] zcvs, input int id);
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.ALU_Sel  = op;
      e.res  = r;
      e.zcvs = zcvs;
      e.id   = id;
      q.push_back(e);
   endtask

   task automatic check_now(input string name, input logic vld, input logic [31:0] r,
                            input logic [3:0] zcvs);
      tests++;
      if (bus.out_valid !== vld || bus.ALU_Out !== r ||
          {bus.Z, bus.C, bus.V, bus.S} !== zcvs) begin
         fails++;
         $display("FAIL %s: got vld=%b out=%h zcvs=%b, expected vld=%b out=%h zcvs=%b",
                  name, bus.out_valid, bus.ALU_Out, {bus.Z, bus.C, bus.V, bus.S},
                  vld, r, zcvs);
      end
   endtask

   // Monitor: outputs are stable at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_out: got out_valid=1 out=%h, expected no result",
                        bus.ALU_Out);
            end else begin
               e = q.pop_front();
               if (bus.ALU_Out !== e.res || {bus.Z, bus.C, bus.V, bus.S} !== e.zcvs) begin
                  fails++;
                  $display("FAIL vec%0d: got out=%h zcvs=%b, expected out=%h zcvs=%b",
                           e.id, bus.ALU_Out, {bus.Z, bus.C, bus.V, bus.S}, e.res, e.zcvs);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bus.in_valid = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      bus.ALU_Sel  = '0;
      repeat (2) @(negedge clk);
      check_now("reset_state", 1'b0, 32'h0, 4'b0000);
      rst_n = 1'b1;

      // flags order: {Z, C, V, S}
      issue(4'h0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000, 0);
      issue(4'h1, 32'h0000_0004, 32'h0000_0005, 32'hFFFF_FFFF, 4'b0101, 1);
      issue(4'h2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b1000, 2);
      issue(4'h3, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0001, 3);
      issue(4'h4, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'b0001, 4);
      issue(4'h5, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0001, 5);
      issue(4'h6, 32'h0000_0003, 32'h0000_0002, 32'h0000_0006, 4'b0000, 6);
      issue(4'h6, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1110, 7);
      issue(4'h7, 32'h0000_0006, 32'h0000_0003, 32'h0000_0002, 4'b0000, 8);
      issue(4'h7, 32'h0000_0006, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0011, 9);
      issue(4'h8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 4'b0000, 10);
      issue(4'h9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 4'b0000, 11);
      issue(4'h8, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1100, 12);
      issue(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011, 13);
      issue(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100, 14);
      issue(4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0010, 15);
      issue(4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000, 16);
      issue(4'h9, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1100, 17);
      issue(4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0110, 18);
      issue(4'h5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b1000, 19);
      issue(4'hC, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 4'b1000, 20);
      issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 21);
`ifdef ALU32_ROTATE_EN
      issue(4'hA, 32'h8000_0001, 32'h0000_0000, 32'h0000_0003, 4'b0100, 22);
      issue(4'hB, 32'h8000_0001, 32'h0000_0000, 32'hC000_0000, 4'b0101, 23);
`else
      issue(4'hA, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1000, 22);
      issue(4'hB, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1000, 23);
`endif
      issue(4'h7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 4'b0000, 24);

      // Idle cycle: out_valid drops, last result and flags hold.
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.ALU_Sel  = 4'h0;
      bus.A        = 32'hDEAD_BEEF;
      @(negedge clk);
      check_now("idle_hold", 1'b0, 32'h0000_0003, 4'b0000);

      // Reset wins over a simultaneous request.
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.A        = 32'h0000_0001;
      bus.B        = 32'h0000_0002;
      bus.ALU_Sel  = 4'h0;
      @(negedge clk);
      check_now("reset_mid_stream", 1'b0, 32'h0, 4'b0000);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_now($sformatf("post_reset_idle%0d", i), 1'b0, 32'h0, 4'b0000);
      end

      repeat (2) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL missing_results: got %0d results outstanding, expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
